// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the packed-digit up/down counter: mode encodings
// and the digit-field offset helper.
package bcd_updown_counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Bit offset of digit i inside the packed count/load vectors.
    function automatic int unsigned digit_lsb(input int unsigned i, input int unsigned dw);
        return i * dw;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit_stage.sv
// One modulo-RADIX digit register with load clamping and limit flags.
module digit_stage #(
    parameter int unsigned RADIX = 10,
    parameter int unsigned DW    = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_step,
    input  logic          i_up,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_digit,
    output logic [DW-1:0] o_digit,
    output logic          o_at_max,
    output logic          o_at_min
);

    localparam logic [DW-1:0] LP_MAX   = DW'(RADIX - 1);
    // One extra bit so RADIX == 2**DW is representable.
    localparam logic [DW:0]   LP_RADIX = (DW + 1)'(RADIX);

    logic [DW-1:0] r_digit;
    logic [DW-1:0] w_load_clamped;
    logic [DW-1:0] w_next_step;

    always_comb begin
        w_load_clamped = i_load_digit;
        if ({1'b0, i_load_digit} >= LP_RADIX) begin
            w_load_clamped = LP_MAX;
        end
        w_next_step = r_digit;
        if (i_up) begin
            w_next_step = o_at_max ? '0 : r_digit + 1'b1;
        end else begin
            w_next_step = o_at_min ? LP_MAX : r_digit - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= w_load_clamped;
        end else if (i_step) begin
            r_digit <= w_next_step;
        end
    end

    assign o_digit  = r_digit;
    assign o_at_max = (r_digit == LP_MAX);
    assign o_at_min = (r_digit == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit radix-parametrised up/down counter with load, wrap/saturate,
// cascade terminal count and a registered limit pulse.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned DW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 up,
    input  logic                 sat,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 limit
);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_step;
    logic              w_at_limit;
    logic              w_hold;
    logic              r_limit;

    assign w_at_limit = (up == MODE_UP) ? (&w_at_max) : (&w_at_min);
    assign w_hold     = (sat == MODE_SAT) & w_at_limit;
    assign tc         = en & w_at_limit;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Ripple: a digit steps only when every lower digit rolls over.
            if (gi == 0) begin : g_lsd
                assign w_step[gi] = en & ~w_hold;
            end else begin : g_upper
                assign w_step[gi] = w_step[gi-1] &
                    ((up == MODE_UP) ? w_at_max[gi-1] : w_at_min[gi-1]);
            end

            digit_stage #(
                .RADIX(RADIX),
                .DW   (DW)
            ) u_stage (
                .i_clk       (clk),
                .i_reset     (reset),
                .i_step      (w_step[gi]),
                .i_up        (up),
                .i_load      (load),
                .i_load_digit(load_val[digit_lsb(gi, DW) +: DW]),
                .o_digit     (count[digit_lsb(gi, DW) +: DW]),
                .o_at_max    (w_at_max[gi]),
                .o_at_min    (w_at_min[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit <= 1'b0;
        end else if (load) begin
            r_limit <= 1'b0;
        end else begin
            r_limit <= tc;
        end
    end

    assign limit = r_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: stimulus queues the expected visible state per cycle,
// a negedge monitor pops and compares against the selected instance.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 2 BCD digits
    logic       m_reset = 1'b1, m_en = 1'b0, m_up = 1'b0, m_sat = 1'b0, m_load = 1'b0;
    logic [7:0] m_lv = 8'h00;
    logic [7:0] m_count;
    logic       m_tc, m_limit;

    bcd_updown_counter #(.DIGITS(2), .RADIX(10), .DW(4)) u_main (
        .clk(clk), .reset(m_reset), .en(m_en), .up(m_up), .sat(m_sat),
        .load(m_load), .load_val(m_lv), .count(m_count), .tc(m_tc), .limit(m_limit)
    );

    // Cascade pair: upper enable driven by lower terminal count
    logic       c_reset = 1'b1, c_en = 1'b0;
    logic [7:0] c_lo, c_hi;
    logic       c_tc_lo, c_tc_hi, c_lim_lo, c_lim_hi;

    bcd_updown_counter #(.DIGITS(2), .RADIX(10), .DW(4)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(1'b1), .sat(1'b0),
        .load(1'b0), .load_val(8'h00), .count(c_lo), .tc(c_tc_lo), .limit(c_lim_lo)
    );

    bcd_updown_counter #(.DIGITS(2), .RADIX(10), .DW(4)) u_hi (
        .clk(clk), .reset(c_reset), .en(c_tc_lo), .up(1'b1), .sat(1'b0),
        .load(1'b0), .load_val(8'h00), .count(c_hi), .tc(c_tc_hi), .limit(c_lim_hi)
    );

    // Binary mode: 3 hex digits
    logic        b_reset = 1'b1, b_en = 1'b0;
    logic [11:0] b_count;
    logic        b_tc, b_limit;

    bcd_updown_counter #(.DIGITS(3), .RADIX(16), .DW(4)) u_bin (
        .clk(clk), .reset(b_reset), .en(b_en), .up(1'b1), .sat(1'b0),
        .load(1'b0), .load_val(12'h000), .count(b_count), .tc(b_tc), .limit(b_limit)
    );

    int unsigned b_pulses = 0;
    always @(posedge clk) if (b_limit === 1'b1) b_pulses <= b_pulses + 1;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [15:0] cnt;
        logic        tc;
        logic        lim;
        bit          chkaux;
        int unsigned aux;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [15:0] a_cnt;
        logic        a_tc, a_lim;
        int unsigned a_aux;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s.late: sampled at cycle %0d, required cycle %0d", e.nm, cyc, e.cyc);
                end else begin
                    case (e.sel)
                        0: begin a_cnt = {8'h00, m_count}; a_tc = m_tc; a_lim = m_limit; a_aux = 0; end
                        1: begin a_cnt = {c_hi, c_lo}; a_tc = c_tc_lo; a_lim = c_lim_lo;
                                 a_aux = {30'd0, c_tc_hi, c_lim_hi}; end
                        default: begin a_cnt = {4'h0, b_count}; a_tc = b_tc; a_lim = b_limit; a_aux = b_pulses; end
                    endcase
                    cmp(e.nm, "count", {16'h0, a_cnt}, {16'h0, e.cnt});
                    cmp(e.nm, "tc", {31'h0, a_tc}, {31'h0, e.tc});
                    cmp(e.nm, "limit", {31'h0, a_lim}, {31'h0, e.lim});
                    if (e.chkaux) cmp(e.nm, "aux", a_aux, e.aux);
                end
            end
        end
    end

    // Drive one cycle of main inputs; expectation is the state visible during this cycle.
    task automatic m_row(input logic rst, ld, e, u, s, input logic [7:0] lv,
                         input logic [7:0] ec, input logic etc, elim, input string nm,
                         input bit chk = 1'b1);
        @(posedge clk);
        #1;
        m_reset = rst; m_load = ld; m_en = e; m_up = u; m_sat = s; m_lv = lv;
        if (chk) q.push_back('{cyc: cyc, sel: 0, cnt: {8'h00, ec}, tc: etc, lim: elim,
                              chkaux: 1'b0, aux: 0, nm: nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        //     rst ld en up sat  lv     count  tc lim
        m_row(1, 1, 0, 0, 0, 8'h57, 8'h00, 0, 0, "reset_with_load", 1'b0);
        m_row(0, 1, 0, 0, 0, 8'h57, 8'h00, 0, 0, "reset_state");
        m_row(0, 1, 0, 0, 0, 8'hAF, 8'h57, 0, 0, "load_57");
        m_row(0, 1, 0, 0, 0, 8'h98, 8'h99, 0, 0, "load_clamp_AF");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h98, 0, 0, "up_from_98");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h99, 1, 0, "up_at_max_tc");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, "up_wrap_limit");
        m_row(0, 1, 0, 0, 0, 8'h01, 8'h01, 0, 0, "up_after_wrap");
        m_row(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 0, "load_01");
        m_row(0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 0, "down_to_min_tc");
        m_row(0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 1, "down_sat_hold1");
        m_row(0, 0, 1, 0, 1, 8'h00, 8'h00, 1, 1, "down_sat_hold2");
        m_row(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, "en_drop_tc");
        m_row(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, "en_low_limit_clear");
        m_row(0, 1, 0, 0, 0, 8'h40, 8'h00, 0, 0, "hold_before_load40");
        m_row(0, 0, 1, 0, 0, 8'h00, 8'h40, 0, 0, "load_40");
        m_row(0, 0, 1, 0, 0, 8'h00, 8'h39, 0, 0, "borrow_39");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h38, 0, 0, "down_38");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h39, 0, 0, "flip_up_39");
        m_row(0, 1, 0, 0, 0, 8'h99, 8'h40, 0, 0, "carry_40");
        m_row(0, 0, 1, 1, 1, 8'h00, 8'h99, 1, 0, "load_99_up_sat");
        m_row(0, 0, 1, 1, 1, 8'h00, 8'h99, 1, 1, "up_sat_hold");
        m_row(0, 1, 1, 0, 0, 8'h00, 8'h99, 0, 1, "load_beats_en");
        m_row(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, "loaded_00_no_step");
        m_row(1, 0, 1, 0, 0, 8'h00, 8'h99, 0, 1, "down_wrap_to_max");
        m_row(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, "reset_mid_count");
        m_row(0, 1, 0, 0, 0, 8'h3C, 8'h01, 0, 0, "step_after_reset");
        m_row(0, 0, 0, 0, 0, 8'h00, 8'h39, 0, 0, "clamp_low_digit_3C");

        // Cascade: 100 enabled up steps, then 5 idle cycles
        m_reset = 1'b1;
        for (int k = 0; k <= 104; k++) begin
            @(posedge clk);
            #1;
            c_reset = 1'b0;
            c_en = (k < 100);
            if (k == 0)
                q.push_back('{cyc: cyc, sel: 1, cnt: 16'h0000, tc: 1'b0, lim: 1'b0, chkaux: 1'b1, aux: 0, nm: "casc_start"});
            else if (k == 99)
                q.push_back('{cyc: cyc, sel: 1, cnt: 16'h0099, tc: 1'b1, lim: 1'b0, chkaux: 1'b1, aux: 0, nm: "casc_99"});
            else if (k == 100)
                q.push_back('{cyc: cyc, sel: 1, cnt: 16'h0100, tc: 1'b0, lim: 1'b1, chkaux: 1'b1, aux: 0, nm: "casc_100"});
            else if (k > 100)
                q.push_back('{cyc: cyc, sel: 1, cnt: 16'h0100, tc: 1'b0, lim: 1'b0, chkaux: 1'b1, aux: 0, nm: "casc_idle"});
        end

        // Binary mode: full 4096-step cycle, one limit pulse expected
        c_reset = 1'b1;
        for (int k = 0; k <= 4097; k++) begin
            @(posedge clk);
            #1;
            b_reset = 1'b0;
            b_en = (k < 4096);
            case (k)
                0:    q.push_back('{cyc: cyc, sel: 2, cnt: 16'h0000, tc: 1'b0, lim: 1'b0, chkaux: 1'b1, aux: 0, nm: "bin_start"});
                10:   q.push_back('{cyc: cyc, sel: 2, cnt: 16'h000A, tc: 1'b0, lim: 1'b0, chkaux: 1'b0, aux: 0, nm: "bin_hex_digit"});
                4095: q.push_back('{cyc: cyc, sel: 2, cnt: 16'h0FFF, tc: 1'b1, lim: 1'b0, chkaux: 1'b1, aux: 0, nm: "bin_max"});
                4096: q.push_back('{cyc: cyc, sel: 2, cnt: 16'h0000, tc: 1'b0, lim: 1'b1, chkaux: 1'b0, aux: 0, nm: "bin_wrap"});
                4097: q.push_back('{cyc: cyc, sel: 2, cnt: 16'h0000, tc: 1'b0, lim: 1'b0, chkaux: 1'b1, aux: 1, nm: "bin_pulse_count"});
                default: ;
            endcase
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
